// File: rtl/vh_sweep_pkg.sv
// Shared types and constants for the exhaustive-sweep MISR harness.
package vh_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    // Number of SIG_WIDTH chunks a zero-padded y splits into before XOR folding.
    function automatic int fold_chunks(input int y_width, input int sig_width);
        return (y_width + sig_width - 1) / sig_width;
    endfunction

endpackage

// File: rtl/vh_sweep_misr_if.sv
// Stimulus, response and signature handshake between the sweep harness and its environment.
interface vh_sweep_misr_if #(
    parameter int IN_WIDTH  = 8,
    parameter int Y_WIDTH   = 16,
    parameter int SIG_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic [IN_WIDTH-1:0]  stim;
    logic                 stim_valid;
    logic [Y_WIDTH-1:0]   y;
    logic                 busy;
    logic [SIG_WIDTH-1:0] sig;
    logic                 sig_valid;
    logic                 sig_ack;

    modport master (
        input  start, abort, y, sig_ack,
        output stim, stim_valid, busy, sig, sig_valid
    );

    modport slave (
        output start, abort, y, sig_ack,
        input  stim, stim_valid, busy, sig, sig_valid
    );
endinterface

// File: rtl/vh_misr.sv
// Multiple-input signature register: folds a wide response word into SIG_WIDTH bits
// and mixes it into a Galois-style LFSR step.
module vh_misr
    import vh_sweep_pkg::*;
#(
    parameter int                   Y_WIDTH   = 16,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY),
    parameter logic [SIG_WIDTH-1:0] RST_VAL   = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SIG_WIDTH-1:0] seed,
    input  logic                 en,
    input  logic [Y_WIDTH-1:0]   din,
    output logic [SIG_WIDTH-1:0] q
);
    localparam int CHUNKS = fold_chunks(Y_WIDTH, SIG_WIDTH);
    localparam int PAD_W  = CHUNKS * SIG_WIDTH;

    logic [PAD_W-1:0]     din_pad;
    logic [SIG_WIDTH-1:0] folded;
    logic [SIG_WIDTH-1:0] step;

    always_comb begin
        din_pad = PAD_W'(din);
        folded  = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            folded = folded ^ din_pad[i*SIG_WIDTH +: SIG_WIDTH];
        end
        step = {q[SIG_WIDTH-2:0], 1'b0} ^ (q[SIG_WIDTH-1] ? POLY : '0) ^ folded;
    end

    // NOTE: non-blocking assignments in clocked processes so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= step;
        end
    end
endmodule

// File: rtl/vh_sweep_misr.sv
// Exhaustive input sweep plus MISR signature capture around a single-input DUT.
// Holds the sweep FSM, the stimulus counter and the capture-valid delay line.
module vh_sweep_misr
    import vh_sweep_pkg::*;
#(
    parameter int                   IN_WIDTH  = 8,
    parameter int                   Y_WIDTH   = 16,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY),
    parameter logic [SIG_WIDTH-1:0] SEED      = '1,
    parameter int                   LAT       = 0
) (
    input logic             clk,
    input logic             rst,
    vh_sweep_misr_if.master bus
);
    localparam logic [IN_WIDTH:0] CNT_ONE    = 1;
    localparam logic [3:0]        DRAIN_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [IN_WIDTH:0] cnt, cnt_inc;
    logic [3:0]        dcnt;
    logic              in_run, flush, misr_load, cap_en;

    assign cnt_inc = cnt + CNT_ONE;
    assign in_run  = (state == RUN);
    assign flush   = bus.abort && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        misr_load = 1'b0;
        case (state)
            IDLE:  if (bus.start) begin
                       state_nxt = RUN;
                       misr_load = 1'b1;
                   end
            // The extra counter MSB flags that all 2**IN_WIDTH values have been driven.
            RUN:   if (cnt_inc[IN_WIDTH]) state_nxt = (LAT == 0) ? DONE : DRAIN;
            DRAIN: if (dcnt == DRAIN_LAST) state_nxt = DONE;
            DONE:  if (bus.sig_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            misr_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dcnt <= '0;
        end else begin
            cnt  <= in_run ? cnt_inc : '0;
            dcnt <= (state == DRAIN) ? dcnt + 4'd1 : 4'd0;
        end
    end

    // Align stim_valid with the DUT's pipelined response.
    generate
        if (LAT == 0) begin : g_no_delay
            assign cap_en = in_run;
        end else begin : g_delay
            logic [LAT-1:0] vld_d;
            always_ff @(posedge clk or posedge rst) begin
                if (rst || 1'b0) begin
                    vld_d <= '0;
                end else if (flush) begin
                    vld_d <= '0;
                end else begin
                    vld_d[0] <= in_run;
                    for (int i = 1; i < LAT; i++) vld_d[i] <= vld_d[i-1];
                end
            end
            assign cap_en = vld_d[LAT-1];
        end
    endgenerate

    vh_misr #(
        .Y_WIDTH  (Y_WIDTH),
        .SIG_WIDTH(SIG_WIDTH),
        .POLY     (POLY),
        .RST_VAL  (SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .load(misr_load),
        .seed(SEED),
        .en  (cap_en),
        .din (bus.y),
        .q   (bus.sig)
    );

    assign bus.stim       = in_run ? cnt[IN_WIDTH-1:0] : '0;
    assign bus.stim_valid = in_run;
    assign bus.busy       = in_run || (state == DRAIN);
    assign bus.sig_valid  = (state == DONE);
endmodule

// File: tb/tb_vh_sweep_misr.sv
// Directed bench: cycle tables for a tiny configuration, then signature checks
// against independent reference models for wider ones.
module tb_vh_sweep_misr;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vh_sweep_misr_if #(.IN_WIDTH(2), .Y_WIDTH(2),  .SIG_WIDTH(4))  if_a ();
    vh_sweep_misr_if #(.IN_WIDTH(2), .Y_WIDTH(2),  .SIG_WIDTH(4))  if_b ();
    vh_sweep_misr_if #(.IN_WIDTH(2), .Y_WIDTH(2),  .SIG_WIDTH(4))  if_c ();
    vh_sweep_misr_if #(.IN_WIDTH(8), .Y_WIDTH(16), .SIG_WIDTH(32)) if_d ();
    vh_sweep_misr_if #(.IN_WIDTH(8), .Y_WIDTH(40), .SIG_WIDTH(16)) if_e ();
    vh_sweep_misr_if #(.IN_WIDTH(8), .Y_WIDTH(40), .SIG_WIDTH(16)) if_f ();

    vh_sweep_misr #(.IN_WIDTH(2), .Y_WIDTH(2), .SIG_WIDTH(4), .POLY(4'h3), .SEED(4'h0), .LAT(0))
        u_a (.clk(clk), .rst(rst), .bus(if_a.master));
    vh_sweep_misr #(.IN_WIDTH(2), .Y_WIDTH(2), .SIG_WIDTH(4), .POLY(4'h3), .SEED(4'h0), .LAT(2))
        u_b (.clk(clk), .rst(rst), .bus(if_b.master));
    vh_sweep_misr #(.IN_WIDTH(2), .Y_WIDTH(2), .SIG_WIDTH(4), .POLY(4'h3), .SEED(4'h0), .LAT(0))
        u_c (.clk(clk), .rst(rst), .bus(if_c.master));
    vh_sweep_misr #(.IN_WIDTH(8), .Y_WIDTH(16), .SIG_WIDTH(32))
        u_d (.clk(clk), .rst(rst), .bus(if_d.master));
    vh_sweep_misr #(.IN_WIDTH(8), .Y_WIDTH(40), .SIG_WIDTH(16), .LAT(0))
        u_e (.clk(clk), .rst(rst), .bus(if_e.master));
    vh_sweep_misr #(.IN_WIDTH(8), .Y_WIDTH(40), .SIG_WIDTH(16), .LAT(0))
        u_f (.clk(clk), .rst(rst), .bus(if_f.master));

    // Stand-in DUTs: combinational for most, a 2-stage pipeline for u_b.
    logic [1:0] yb1, yb2;
    always @(posedge clk) begin
        yb1 <= if_b.stim;
        yb2 <= yb1;
    end
    assign if_a.y = if_a.stim;
    assign if_b.y = yb2;
    assign if_c.y = 2'b00;
    assign if_d.y = {if_d.stim, if_d.stim ^ 8'h5A};
    assign if_e.y = {24'h0, if_e.stim, if_e.stim};
    assign if_f.y = {if_f.stim, if_f.stim ^ 8'h3C, if_f.stim, 8'hC3, if_f.stim};

    typedef struct {
        logic       start;
        logic       abort;
        logic       ack;
        logic [1:0] stim;
        logic       sv;
        logic       busy;
        logic       sigv;
        logic [3:0] sig;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_d();
        logic [31:0] s;
        logic [15:0] yv;
        logic [7:0]  v;
        s = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) begin
            v  = 8'(i);
            yv = {v, v ^ 8'h5A};
            s  = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {16'h0, yv};
        end
        return s;
    endfunction

    function automatic logic [15:0] ref_ef(input bit wide);
        logic [15:0] s;
        logic [47:0] p;
        logic [7:0]  v;
        s = 16'hFFFF;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            if (wide) p = {8'h0, v, v ^ 8'h3C, v, 8'hC3, v};
            else      p = {32'h0, v, v};
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1DB7 : 16'h0) ^ (p[15:0] ^ p[31:16] ^ p[47:32]);
        end
        return s;
    endfunction

    task automatic run_d(input string tag);
        int c;
        if_d.start = 1'b1;
        @(negedge clk);
        if_d.start = 1'b0;
        c = 1;
        while (!if_d.sig_valid && c < 400) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_valid_cycle"}, 64'(c), 64'd257);
        check({tag, "_sig"}, 64'(if_d.sig), 64'(ref_d()));
        if_d.sig_ack = 1'b1;
        @(negedge clk);
        if_d.sig_ack = 1'b0;
        check({tag, "_ack_idle"}, 64'(if_d.sig_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        {if_a.start, if_a.abort, if_a.sig_ack} = '0;
        {if_b.start, if_b.abort, if_b.sig_ack} = '0;
        {if_c.start, if_c.abort, if_c.sig_ack} = '0;
        {if_d.start, if_d.abort, if_d.sig_ack} = '0;
        {if_e.start, if_e.abort, if_e.sig_ack} = '0;
        {if_f.start, if_f.abort, if_f.sig_ack} = '0;

        //          start abort ack   stim  sv    busy  sigv  sig
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'h1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'h3};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'h3};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h3};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h3};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_a_stim",  64'(if_a.stim), 64'd0);
        check("rst_a_sv",    64'(if_a.stim_valid), 64'd0);
        check("rst_a_busy",  64'(if_a.busy), 64'd0);
        check("rst_a_sigv",  64'(if_a.sig_valid), 64'd0);
        check("rst_a_sig",   64'(if_a.sig), 64'h0);
        check("rst_d_sig",   64'(if_d.sig), 64'hFFFF_FFFF);
        check("rst_e_sig",   64'(if_e.sig), 64'hFFFF);
        rst = 1'b0;
        @(negedge clk);

        // Cycle-by-cycle table on u_a (y = stim, LAT = 0).
        for (int i = 0; i < 10; i++) begin
            if_a.start   = tbl[i].start;
            if_a.abort   = tbl[i].abort;
            if_a.sig_ack = tbl[i].ack;
            @(negedge clk);
            check($sformatf("a_row%0d_stim", i), 64'(if_a.stim), 64'(tbl[i].stim));
            check($sformatf("a_row%0d_sv", i),   64'(if_a.stim_valid), 64'(tbl[i].sv));
            check($sformatf("a_row%0d_busy", i), 64'(if_a.busy), 64'(tbl[i].busy));
            check($sformatf("a_row%0d_sigv", i), 64'(if_a.sig_valid), 64'(tbl[i].sigv));
            check($sformatf("a_row%0d_sig", i),  64'(if_a.sig), 64'(tbl[i].sig));
        end
        {if_a.start, if_a.abort, if_a.sig_ack} = '0;

        // LAT = 2 timing, with start pulses in RUN and in DONE that must be ignored.
        if_b.start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if_b.start = (cyc == 2) || (cyc == 7);
            check($sformatf("b_c%0d_busy", cyc), 64'(if_b.busy), 64'(cyc <= 6));
            check($sformatf("b_c%0d_sigv", cyc), 64'(if_b.sig_valid), 64'(cyc >= 7));
        end
        if_b.start = 1'b0;
        check("b_sig", 64'(if_b.sig), 64'h3);
        if_b.sig_ack = 1'b1;
        @(negedge clk);
        if_b.sig_ack = 1'b0;
        check("b_ack_idle", 64'(if_b.sig_valid), 64'd0);

        // y tied low; signature holds while unacknowledged.
        if_c.start = 1'b1;
        @(negedge clk);
        if_c.start = 1'b0;
        c = 1;
        while (!if_c.sig_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("c_valid_cycle", 64'(c), 64'd5);
        check("c_sig", 64'(if_c.sig), 64'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("c_hold%0d_sigv", i), 64'(if_c.sig_valid), 64'd1);
            check($sformatf("c_hold%0d_sig", i),  64'(if_c.sig), 64'h0);
        end
        if_c.sig_ack = 1'b1;
        @(negedge clk);
        if_c.sig_ack = 1'b0;
        check("c_ack_sigv", 64'(if_c.sig_valid), 64'd0);
        check("c_ack_busy", 64'(if_c.busy), 64'd0);

        // Default configuration: clean sweep, aborted sweep, then a fresh sweep.
        run_d("d_clean");
        if_d.start = 1'b1;
        @(negedge clk);
        if_d.start = 1'b0;
        repeat (100) @(negedge clk);
        check("d_abort_index", 64'(if_d.stim), 64'd100);
        if_d.abort = 1'b1;
        @(negedge clk);
        if_d.abort = 1'b0;
        check("d_abort_sv",   64'(if_d.stim_valid), 64'd0);
        check("d_abort_stim", 64'(if_d.stim), 64'd0);
        check("d_abort_sig",  64'(if_d.sig), 64'hFFFF_FFFF);
        check("d_abort_busy", 64'(if_d.busy), 64'd0);
        check("d_abort_sigv", 64'(if_d.sig_valid), 64'd0);
        run_d("d_after_abort");

        // Wide y folded into a narrower MISR.
        if_e.start = 1'b1;
        if_f.start = 1'b1;
        @(negedge clk);
        if_e.start = 1'b0;
        if_f.start = 1'b0;
        c = 1;
        while (!(if_e.sig_valid && if_f.sig_valid) && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("ef_valid_cycle", 64'(c), 64'd257);
        check("e_sig", 64'(if_e.sig), 64'(ref_ef(1'b0)));
        check("f_sig", 64'(if_f.sig), 64'(ref_ef(1'b1)));

        // Asynchronous reset between edges, mid-RUN.
        if_d.start = 1'b1;
        @(negedge clk);
        if_d.start = 1'b0;
        repeat (50) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_d_sv",   64'(if_d.stim_valid), 64'd0);
        check("arst_d_stim", 64'(if_d.stim), 64'd0);
        check("arst_d_busy", 64'(if_d.busy), 64'd0);
        check("arst_d_sig",  64'(if_d.sig), 64'hFFFF_FFFF);
        check("arst_d_sigv", 64'(if_d.sig_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_d("d_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
